// File: rtl/mult_mod_mux_wrapper.sv
// Shares one multiplier core among NUM_CH clients: per-channel skid buffers, round-robin issue, tagged result return.
// Per-channel issue counters exist only when MULT_MOD_MUX_CNT_EN is defined.
module mult_mod_mux_wrapper #(
  parameter int BITS     = 381,
  parameter int NUM_CH   = 4,
  parameter int CTL_BITS = 8,
  parameter int MAX_OUT  = 8,
  parameter int RAM_D_W  = 32,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_CH-1:0]          i_val,
  output logic [NUM_CH-1:0]          o_rdy,
  input  logic [NUM_CH*BITS-1:0]     i_dat_a,
  input  logic [NUM_CH*BITS-1:0]     i_dat_b,
  input  logic [NUM_CH*CTL_BITS-1:0] i_ctl,
  output logic [NUM_CH-1:0]          o_val,
  input  logic [NUM_CH-1:0]          i_rdy,
  output logic [NUM_CH*BITS-1:0]     o_dat,
  output logic [NUM_CH*CTL_BITS-1:0] o_ctl,
  output logic                       o_mul_val,
  input  logic                       i_mul_rdy,
  output logic [2*BITS-1:0]          o_mul_dat,
  output logic [CTL_BITS+CH_W-1:0]   o_mul_ctl,
  input  logic                       i_res_val,
  output logic                       o_res_rdy,
  input  logic [BITS-1:0]            i_res_dat,
  input  logic [CTL_BITS+CH_W-1:0]   i_res_ctl,
  input  logic [RAM_D_W-1:0]         i_ram_d,
  input  logic                       i_ram_we,
  input  logic                       i_ram_se,
  output logic [RAM_D_W-1:0]         o_ram_d,
  output logic                       o_ram_we,
  output logic                       o_ram_se,
  output logic                       o_err,
  output logic [NUM_CH*32-1:0]       o_cnt_issue
);

  localparam int E_W = CTL_BITS + 2*BITS;
  localparam logic [31:0] NUM_CH_U = NUM_CH;

  logic [E_W-1:0]    buf0 [NUM_CH];
  logic [E_W-1:0]    buf1 [NUM_CH];
  logic [E_W-1:0]    in_entry [NUM_CH];
  logic [E_W-1:0]    head;
  logic [1:0]        buf_cnt [NUM_CH];
  logic [1:0]        cnt_nxt [NUM_CH];
  logic [7:0]        in_flight [NUM_CH];
  logic [NUM_CH-1:0] push, pop, eligible, res_hit;
  logic [CH_W-1:0]   ptr, grant, res_chan;
  logic              grant_val, load, issue, res_bad, res_acc;
  int                idx;

  always_comb begin
    eligible  = '0;
    grant     = '0;
    grant_val = 1'b0;
    idx       = 0;
    for (int c = 0; c < NUM_CH; c++)
      eligible[c] = (buf_cnt[c] != 2'd0) && (in_flight[c] < 8'(MAX_OUT)) && !o_ram_se;
    // Scan from the pointer upward and wrap; the first eligible channel wins.
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_val && eligible[idx]) begin
        grant_val = 1'b1;
        grant     = CH_W'(idx);
      end
    end
  end

  assign load  = !o_mul_val || i_mul_rdy;
  assign issue = load && grant_val;
  assign head  = buf0[grant];

  always_comb begin
    push = '0;
    pop  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      push[c]     = i_val[c] && o_rdy[c];
      pop[c]      = issue && (grant == CH_W'(c));
      in_entry[c] = {i_ctl[c*CTL_BITS +: CTL_BITS], i_dat_b[c*BITS +: BITS], i_dat_a[c*BITS +: BITS]};
      cnt_nxt[c]  = buf_cnt[c] + 2'(push[c]) - 2'(pop[c]);
    end
  end

  // A tag outside the channel range is swallowed so the core never stalls on it.
  always_comb begin
    res_chan  = i_res_ctl[CTL_BITS +: CH_W];
    res_bad   = {{(32-CH_W){1'b0}}, res_chan} >= NUM_CH_U;
    o_res_rdy = 1'b1;
    res_hit   = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (res_chan == CH_W'(c)) o_res_rdy = !o_val[c] || i_rdy[c];
    res_acc = i_res_val && o_res_rdy && !res_bad;
    for (int c = 0; c < NUM_CH; c++)
      res_hit[c] = res_acc && (res_chan == CH_W'(c));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdy     <= '0;
      o_mul_val <= 1'b0;
      ptr       <= '0;
      o_val     <= '0;
      o_err     <= 1'b0;
      o_ram_we  <= 1'b0;
      o_ram_se  <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        buf_cnt[c]   <= 2'd0;
        in_flight[c] <= 8'd0;
      end
    end else begin
      o_ram_we <= i_ram_we;
      o_ram_se <= i_ram_se;
      if (load) o_mul_val <= grant_val;
      if (issue) ptr <= (grant == CH_W'(NUM_CH-1)) ? '0 : grant + 1'b1;
      if (i_res_val && res_bad) o_err <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        buf_cnt[c] <= cnt_nxt[c];
        o_rdy[c]   <= cnt_nxt[c] < 2'd2;
        if (pop[c] && !res_hit[c]) in_flight[c] <= in_flight[c] + 8'd1;
        else if (!pop[c] && res_hit[c]) in_flight[c] <= in_flight[c] - 8'd1;
        if (res_hit[c]) o_val[c] <= 1'b1;
        else if (i_rdy[c]) o_val[c] <= 1'b0;
      end
    end
  end

  // Payload registers carry no reset; their valid bits above qualify them.
  always_ff @(posedge i_clk) begin
    o_ram_d <= i_ram_d;
    if (issue) begin
      o_mul_dat <= head[2*BITS-1:0];
      o_mul_ctl <= {grant, head[E_W-1 -: CTL_BITS]};
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (pop[c]) buf0[c] <= (push[c] && buf_cnt[c] == 2'd1) ? in_entry[c] : buf1[c];
      else if (push[c] && buf_cnt[c] == 2'd0) buf0[c] <= in_entry[c];
      else if (push[c]) buf1[c] <= in_entry[c];
      if (res_hit[c]) begin
        o_dat[c*BITS +: BITS]         <= i_res_dat;
        o_ctl[c*CTL_BITS +: CTL_BITS] <= i_res_ctl[CTL_BITS-1:0];
      end
    end
  end

`ifdef MULT_MOD_MUX_CNT_EN
  logic [31:0] cnt_issue [NUM_CH];

  always_ff @(posedge i_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (i_rst) cnt_issue[c] <= '0;
      else if (pop[c] && cnt_issue[c] != 32'hFFFF_FFFF) cnt_issue[c] <= cnt_issue[c] + 32'd1;
    end
  end

  always_comb begin
    o_cnt_issue = '0;
    for (int c = 0; c < NUM_CH; c++) o_cnt_issue[c*32 +: 32] = cnt_issue[c];
  end
`else
  assign o_cnt_issue = '0;
`endif

endmodule

// File: tb/tb_mult_mod_mux_wrapper.sv
// Randomised bench for mult_mod_mux_wrapper: a behavioural core and per-channel scoreboards predict every handshake.
// Counter expectations follow MULT_MOD_MUX_CNT_EN.
module tb_mult_mod_mux_wrapper;

`ifdef MULT_MOD_MUX_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]   val, rdy, oval, irdy;
  logic [63:0]  dat_a, dat_b, odat;
  logic [31:0]  ctl, octl, ram_d, oram_d;
  logic         mul_val, mul_rdy, res_val, res_rdy, ram_we, ram_se, oram_we, oram_se, err;
  logic [31:0]  mul_dat;
  logic [9:0]   mul_ctl, res_ctl;
  logic [15:0]  res_dat;
  logic [127:0] cnt_issue;

  logic [2:0]   val3, rdy3, oval3, irdy3;
  logic [47:0]  dat_a3, dat_b3, odat3;
  logic [23:0]  ctl3, octl3;
  logic         mul_val3, mul_rdy3, res_val3, res_rdy3, ram_we3, ram_se3, oram_we3, oram_se3, err3;
  logic [31:0]  mul_dat3, ram_d3, oram_d3;
  logic [9:0]   mul_ctl3, res_ctl3;
  logic [15:0]  res_dat3;
  logic [95:0]  cnt_issue3;

  int n_checks = 0;
  int n_fail = 0;

  logic [39:0] pend_q [4][$];
  logic [23:0] exp_q [4][$];
  logic [25:0] core_q [$];

  always #5 clk = ~clk;

  mult_mod_mux_wrapper #(.BITS(16), .NUM_CH(4), .CTL_BITS(8), .MAX_OUT(2), .RAM_D_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_val(val), .o_rdy(rdy), .i_dat_a(dat_a), .i_dat_b(dat_b),
    .i_ctl(ctl), .o_val(oval), .i_rdy(irdy), .o_dat(odat), .o_ctl(octl),
    .o_mul_val(mul_val), .i_mul_rdy(mul_rdy), .o_mul_dat(mul_dat), .o_mul_ctl(mul_ctl),
    .i_res_val(res_val), .o_res_rdy(res_rdy), .i_res_dat(res_dat), .i_res_ctl(res_ctl),
    .i_ram_d(ram_d), .i_ram_we(ram_we), .i_ram_se(ram_se), .o_ram_d(oram_d),
    .o_ram_we(oram_we), .o_ram_se(oram_se), .o_err(err), .o_cnt_issue(cnt_issue)
  );

  mult_mod_mux_wrapper #(.BITS(16), .NUM_CH(3), .CTL_BITS(8), .MAX_OUT(2), .RAM_D_W(32)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_val(val3), .o_rdy(rdy3), .i_dat_a(dat_a3), .i_dat_b(dat_b3),
    .i_ctl(ctl3), .o_val(oval3), .i_rdy(irdy3), .o_dat(odat3), .o_ctl(octl3),
    .o_mul_val(mul_val3), .i_mul_rdy(mul_rdy3), .o_mul_dat(mul_dat3), .o_mul_ctl(mul_ctl3),
    .i_res_val(res_val3), .o_res_rdy(res_rdy3), .i_res_dat(res_dat3), .i_res_ctl(res_ctl3),
    .i_ram_d(ram_d3), .i_ram_we(ram_we3), .i_ram_se(ram_se3), .o_ram_d(oram_d3),
    .o_ram_we(oram_we3), .o_ram_se(oram_se3), .o_err(err3), .o_cnt_issue(cnt_issue3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    val = '0; dat_a = '0; dat_b = '0; ctl = '0; irdy = '1; mul_rdy = 1'b0;
    res_val = 1'b0; res_dat = '0; res_ctl = '0; ram_d = '0; ram_we = 1'b0; ram_se = 1'b0;
    val3 = '0; dat_a3 = '0; dat_b3 = '0; ctl3 = '0; irdy3 = '1; mul_rdy3 = 1'b0;
    res_val3 = 1'b0; res_dat3 = '0; res_ctl3 = '0; ram_d3 = '0; ram_we3 = 1'b0; ram_se3 = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    ram_we = 1'b1; ram_se = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (oval !== 4'h0 || mul_val !== 1'b0 || rdy !== 4'h0 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: oval=%h mul_val=%b rdy=%h err=%b, required 0 0 0 0", oval, mul_val, rdy, err);
    end
    n_checks++;
    if (oram_we !== 1'b0 || oram_se !== 1'b0 || cnt_issue !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_ram_cnt: we=%b se=%b cnt=%h, required 0", oram_we, oram_se, cnt_issue);
    end
    n_checks++;
    if (oval3 !== 3'h0 || err3 !== 1'b0 || rdy3 !== 3'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_dut3: oval=%h err=%b rdy=%h, required 0", oval3, err3, rdy3);
    end
    rst = 1'b0; ram_we = 1'b0; ram_se = 1'b0;
    tick();
    n_checks++;
    if (rdy !== 4'hF || rdy3 !== 3'h7) begin
      n_fail++;
      $display("[TB] FAIL reset_release_rdy: rdy=%h rdy3=%h, required f 7", rdy, rdy3);
    end
  endtask

  task automatic test_single();
    mul_rdy = 1'b1;
    val[2] = 1'b1; dat_a[47:32] = 16'd3; dat_b[47:32] = 16'd5; ctl[23:16] = 8'h11;
    tick();
    val = '0;
    n_checks++;
    if (mul_val !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_early: mul_val=%b, required 0", mul_val);
    end
    tick();
    n_checks++;
    if (mul_val !== 1'b1 || mul_ctl !== 10'h211 || mul_dat !== {16'd5, 16'd3}) begin
      n_fail++;
      $display("[TB] FAIL single_issue: val=%b ctl=%h dat=%h, required 1 211 00050003", mul_val, mul_ctl, mul_dat);
    end
    tick();
    n_checks++;
    if (mul_val !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_consumed: mul_val=%b, required 0", mul_val);
    end
    res_val = 1'b1; res_dat = 16'd15; res_ctl = 10'h211; irdy = 4'h0;
    #1;
    n_checks++;
    if (res_rdy !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_res_rdy: res_rdy=%b, required 1", res_rdy);
    end
    tick();
    res_val = 1'b0;
    n_checks++;
    if (oval !== 4'b0100 || odat[47:32] !== 16'd15 || octl[23:16] !== 8'h11) begin
      n_fail++;
      $display("[TB] FAIL single_result: oval=%b dat=%0d ctl=%h, required 0100 15 11", oval, odat[47:32], octl[23:16]);
    end
    irdy = 4'hF;
    tick();
    n_checks++;
    if (oval !== 4'h0) begin
      n_fail++;
      $display("[TB] FAIL single_drain: oval=%b, required 0000", oval);
    end
  endtask

  // mode 0: saturating traffic with a prompt core; mode 1: random valids, ready and core latency.
  task automatic test_traffic(input int mode);
    int pushed [4];
    int issued_n = 0;
    logic [3:0] acc, ohs;
    logic mhs, rhs, feeding, done;
    logic [31:0] cap_mdat, prod;
    logic [9:0] cap_mctl;
    logic [63:0] cap_odat;
    logic [31:0] cap_octl;
    logic [39:0] ent;
    logic [25:0] cent;
    int ch;
    pulse_reset();
    for (int c = 0; c < 4; c++) begin
      pend_q[c].delete(); exp_q[c].delete(); pushed[c] = 0;
    end
    core_q.delete();
    done = 1'b0;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      feeding = (mode == 0) ? (issued_n < 40) : (cyc < 400);
      for (int c = 0; c < 4; c++) begin
        val[c] = feeding && ((mode == 0) || ($urandom_range(1, 0) == 1));
        dat_a[c*16 +: 16] = 16'($urandom);
        dat_b[c*16 +: 16] = 16'($urandom);
        ctl[c*8 +: 8] = 8'($urandom);
        irdy[c] = (mode == 0) || ($urandom_range(2, 0) != 0);
      end
      mul_rdy = (mode == 0) || ($urandom_range(3, 0) != 0);
      res_val = (core_q.size() > 0) && ((mode == 0) || ($urandom_range(1, 0) == 1));
      if (core_q.size() > 0) begin
        res_ctl = core_q[0][25:16];
        res_dat = core_q[0][15:0];
      end
      #1;
      acc = val & rdy;
      mhs = mul_val && mul_rdy;
      cap_mdat = mul_dat; cap_mctl = mul_ctl;
      rhs = res_val && res_rdy;
      ohs = oval & irdy;
      cap_odat = odat; cap_octl = octl;
      tick();
      for (int c = 0; c < 4; c++) begin
        if (acc[c]) begin
          pend_q[c].push_back({ctl[c*8 +: 8], dat_b[c*16 +: 16], dat_a[c*16 +: 16]});
          pushed[c]++;
        end
        if (ohs[c]) begin
          n_checks++;
          if (exp_q[c].size() == 0) begin
            n_fail++;
            $display("[TB] FAIL traffic_spurious_out: ch%0d delivered %h with nothing expected", c, cap_odat[c*16 +: 16]);
          end else begin
            if ({cap_octl[c*8 +: 8], cap_odat[c*16 +: 16]} !== exp_q[c][0]) begin
              n_fail++;
              $display("[TB] FAIL traffic_out: ch%0d got %h%h, required %h", c, cap_octl[c*8 +: 8], cap_odat[c*16 +: 16], exp_q[c][0]);
            end
            void'(exp_q[c].pop_front());
          end
        end
      end
      if (mhs) begin
        ch = int'(cap_mctl[9:8]);
        n_checks++;
        if (pend_q[ch].size() == 0) begin
          n_fail++;
          $display("[TB] FAIL traffic_spurious_issue: ch%0d issued %h with nothing pending", ch, cap_mdat);
        end else begin
          ent = pend_q[ch].pop_front();
          if (cap_mdat !== ent[31:0] || cap_mctl[7:0] !== ent[39:32]) begin
            n_fail++;
            $display("[TB] FAIL traffic_issue: ch%0d got %h/%h, required %h/%h", ch, cap_mdat, cap_mctl[7:0], ent[31:0], ent[39:32]);
          end
        end
        if (mode == 0 && issued_n < 40) begin
          n_checks++;
          if (ch != issued_n % 4) begin
            n_fail++;
            $display("[TB] FAIL rr_order: issue %0d went to ch%0d, required ch%0d", issued_n, ch, issued_n % 4);
          end
        end
        prod = 32'(cap_mdat[15:0]) * 32'(cap_mdat[31:16]);
        core_q.push_back({cap_mctl, prod[15:0]});
        issued_n++;
      end
      if (rhs) begin
        cent = core_q.pop_front();
        exp_q[int'(cent[25:24])].push_back(cent[23:0]);
      end
      done = !feeding && core_q.size() == 0 && oval == 4'h0 && !mul_val;
      for (int c = 0; c < 4; c++)
        done = done && pend_q[c].size() == 0 && exp_q[c].size() == 0;
    end
    val = '0; res_val = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("[TB] FAIL traffic_timeout: mode %0d did not drain, issued %0d", mode, issued_n);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (cnt_issue[c*32 +: 32] !== (CNT_EN ? 32'(pushed[c]) : 32'd0)) begin
        n_fail++;
        $display("[TB] FAIL issue_count: ch%0d count=%0d, required %0d", c, cnt_issue[c*32 +: 32], CNT_EN ? pushed[c] : 0);
      end
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL traffic_err: err=%b, required 0", err);
    end
  endtask

  task automatic test_max_out();
    int k = 0;
    int hs = 0;
    logic a_ok, m_ok;
    pulse_reset();
    mul_rdy = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      val[0] = (k < 4);
      dat_a[15:0] = 16'(k + 10); dat_b[15:0] = 16'(k + 20); ctl[7:0] = 8'(k);
      #1;
      a_ok = val[0] && rdy[0];
      m_ok = mul_val && mul_rdy;
      tick();
      if (a_ok) k++;
      if (m_ok) hs++;
    end
    val = '0;
    n_checks++;
    if (k != 4 || hs != 2 || mul_val !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL max_out_limit: accepted %0d issued %0d mul_val=%b, required 4 2 0", k, hs, mul_val);
    end
    res_val = 1'b1; res_ctl = 10'h000; res_dat = 16'h1234;
    tick();
    res_val = 1'b0;
    n_checks++;
    if (mul_val !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL max_out_early: mul_val=%b, required 0", mul_val);
    end
    tick();
    n_checks++;
    if (mul_val !== 1'b1 || mul_dat !== {16'd22, 16'd12} || mul_ctl !== 10'h002) begin
      n_fail++;
      $display("[TB] FAIL max_out_third: val=%b dat=%h ctl=%h, required 1 0016000c 002", mul_val, mul_dat, mul_ctl);
    end
    tick();
    tick();
    n_checks++;
    if (mul_val !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL max_out_fourth: mul_val=%b, required 0", mul_val);
    end
  endtask

  task automatic test_stall_se();
    logic [31:0] d0, rd;
    logic [9:0] c0;
    pulse_reset();
    mul_rdy = 1'b0;
    val[1] = 1'b1; dat_a[31:16] = 16'($urandom); dat_b[31:16] = 16'($urandom); ctl[15:8] = 8'h77;
    tick();
    val = '0;
    val[3] = 1'b1; dat_a[63:48] = 16'($urandom); dat_b[63:48] = 16'($urandom); ctl[31:24] = 8'h33;
    tick();
    val = '0;
    n_checks++;
    if (mul_val !== 1'b1 || mul_ctl !== 10'h177 || mul_dat !== {dat_b[31:16], dat_a[31:16]}) begin
      n_fail++;
      $display("[TB] FAIL stall_loaded: val=%b ctl=%h dat=%h, required 1 177 %h", mul_val, mul_ctl, mul_dat, {dat_b[31:16], dat_a[31:16]});
    end
    d0 = mul_dat; c0 = mul_ctl;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (mul_val !== 1'b1 || mul_dat !== d0 || mul_ctl !== c0) begin
        n_fail++;
        $display("[TB] FAIL stall_hold: cycle %0d val=%b dat=%h ctl=%h, required 1 %h %h", i, mul_val, mul_dat, mul_ctl, d0, c0);
      end
    end
    rd = $urandom;
    ram_d = rd; ram_we = 1'b1; ram_se = 1'b1;
    #1;
    n_checks++;
    if (oram_se !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL ram_se_early: o_ram_se=%b, required 0", oram_se);
    end
    tick();
    n_checks++;
    if (oram_se !== 1'b1 || oram_we !== 1'b1 || oram_d !== rd) begin
      n_fail++;
      $display("[TB] FAIL ram_reg: se=%b we=%b d=%h, required 1 1 %h", oram_se, oram_we, oram_d, rd);
    end
    mul_rdy = 1'b1; ram_we = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (mul_val !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL se_block: mul_val=%b, required 0", mul_val);
    end
    ram_se = 1'b0;
    tick();
    n_checks++;
    if (mul_val !== 1'b0 || oram_se !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL se_release_lag: mul_val=%b o_ram_se=%b, required 0 0", mul_val, oram_se);
    end
    tick();
    n_checks++;
    if (mul_val !== 1'b1 || mul_ctl !== 10'h333) begin
      n_fail++;
      $display("[TB] FAIL se_release_grant: val=%b ctl=%h, required 1 333", mul_val, mul_ctl);
    end
  endtask

  task automatic test_bad_tag();
    pulse_reset();
    res_val3 = 1'b1; res_ctl3 = {2'd3, 8'h5A}; res_dat3 = 16'hBEEF; irdy3 = 3'h0;
    #1;
    n_checks++;
    if (res_rdy3 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bad_tag_rdy: res_rdy=%b, required 1", res_rdy3);
    end
    tick();
    res_ctl3 = {2'd1, 8'h22};
    n_checks++;
    if (oval3 !== 3'h0 || err3 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bad_tag_drop: oval=%b err=%b, required 000 1", oval3, err3);
    end
    tick();
    #1;
    n_checks++;
    if (oval3 !== 3'b010 || res_rdy3 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL good_tag_block: oval=%b res_rdy=%b, required 010 0", oval3, res_rdy3);
    end
    res_val3 = 1'b0;
    tick();
    tick();
    n_checks++;
    if (err3 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL bad_tag_sticky: err=%b, required 1", err3);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (err3 !== 1'b0 || oval3 !== 3'h0) begin
      n_fail++;
      $display("[TB] FAIL bad_tag_clear: err=%b oval=%b, required 0 000", err3, oval3);
    end
    irdy3 = '1;
    tick();
  endtask

  task automatic test_reset_mid();
    int sent [3];
    int hs = 0;
    logic m_ok;
    logic [2:0] a_ok;
    pulse_reset();
    mul_rdy = 1'b1;
    sent[0] = 0; sent[1] = 0; sent[2] = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      val[0] = sent[0] < 3; val[1] = sent[1] < 1; val[2] = sent[2] < 1;
      #1;
      a_ok = val[2:0] & rdy[2:0];
      tick();
      for (int c = 0; c < 3; c++) if (a_ok[c]) sent[c]++;
    end
    val = '0;
    res_val = 1'b1; res_ctl = 10'h100; irdy = 4'h0;
    tick();
    res_val = 1'b0;
    n_checks++;
    if (oval !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL mid_setup: oval=%b, required 0010", oval);
    end
    ram_we = 1'b1; ram_se = 1'b1; rst = 1'b1;
    tick();
    n_checks++;
    if (oval !== 4'h0 || mul_val !== 1'b0 || rdy !== 4'h0 || oram_we !== 1'b0 || oram_se !== 1'b0 || err !== 1'b0 || cnt_issue !== '0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset: oval=%b mul_val=%b rdy=%h we=%b se=%b err=%b, required all 0", oval, mul_val, rdy, oram_we, oram_se, err);
    end
    rst = 1'b0; ram_we = 1'b0; ram_se = 1'b0; irdy = 4'hF;
    tick();
    n_checks++;
    if (rdy !== 4'hF) begin
      n_fail++;
      $display("[TB] FAIL mid_release_rdy: rdy=%h, required f", rdy);
    end
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (mul_val !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_buffers_flushed: mul_val=%b, required 0", mul_val);
    end
    sent[0] = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      val[0] = sent[0] < 2;
      #1;
      a_ok[0] = val[0] && rdy[0];
      m_ok = mul_val && mul_rdy;
      tick();
      if (a_ok[0]) sent[0]++;
      if (m_ok) hs++;
    end
    val = '0;
    n_checks++;
    if (hs != 2) begin
      n_fail++;
      $display("[TB] FAIL mid_inflight_cleared: issued %0d, required 2", hs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_traffic(0);
    test_traffic(1);
    test_max_out();
    test_stall_se();
    test_bad_tag();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
